// File: rtl/bus_window_multi.sv
// N-way addressing window: decodes parent-bus accesses against NUM_WIN base/size
// pairs, forwards them registered to one sub-bus and retires hung accesses by timeout.
module bus_window_multi #(
  parameter int                    NUM_WIN       = 4,
  parameter logic [NUM_WIN*32-1:0] BASE_ADDRS    = {32'h300, 32'h200, 32'h100, 32'h000},
  parameter logic [NUM_WIN*8-1:0]  ADDRWIDTHS    = {8'd8, 8'd8, 8'd8, 8'd8},
  parameter int                    TIMEOUT       = 255,
  parameter logic [31:0]           TIMEOUT_DATA  = 32'hDEAD_BEEF,
  localparam int                   BUS_IN_WIDTH  = 72,
  localparam int                   BUS_OUT_WIDTH = 35
) (
  input  logic                             bus_clk,
  input  logic                             bus_reset_l,
  input  logic [BUS_IN_WIDTH-1:0]          bus_in,
  output logic [BUS_OUT_WIDTH-1:0]         bus_out,
  output logic [NUM_WIN*BUS_IN_WIDTH-1:0]  sub_bus_in,
  input  logic [NUM_WIN*BUS_OUT_WIDTH-1:0] sub_bus_out,
  output logic                             busy,
  output logic                             timeout_pulse,
  output logic                             drop_pulse,
  output logic [7:0]                       timeout_count
);

  localparam int SEL_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

  // Request layout: {BE[3:0], WR_DATA[31:0], ADDR[31:0], WR_REQ, RD_REQ, RESET_L, CLK}
  // Return layout:  {RD_DATA[31:0], RD_ACK, WR_ACK, IRQ}
  localparam int BI_RD    = 2;
  localparam int BI_WR    = 3;
  localparam int BI_ADDR  = 4;
  localparam int BI_WDATA = 36;
  localparam int BI_BE    = 68;
  localparam int BO_IRQ   = 0;
  localparam int BO_WACK  = 1;
  localparam int BO_RACK  = 2;
  localparam int BO_RDATA = 3;

  typedef enum logic {IDLE, BUSY} state_t;

  logic        p_rd, p_wr;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  logic        unused_parent_bits;

  assign p_rd               = bus_in[BI_RD];
  assign p_wr               = bus_in[BI_WR];
  assign p_addr             = bus_in[BI_ADDR +: 32];
  assign p_wdata            = bus_in[BI_WDATA +: 32];
  assign p_be               = bus_in[BI_BE +: 4];
  assign unused_parent_bits = ^bus_in[1:0];

  logic [NUM_WIN-1:0] s_irq, s_wack, s_rack;
  logic [31:0]        s_rdata [NUM_WIN];

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic               kind_rd;
  logic [15:0]        cnt;
  logic [NUM_WIN-1:0] sub_rd, sub_wr;
  logic [31:0]        sub_addr  [NUM_WIN];
  logic [31:0]        sub_wdata [NUM_WIN];
  logic [3:0]         sub_be    [NUM_WIN];
  logic               irq_q, wr_ack_q, rd_ack_q;
  logic [31:0]        rd_data_q;

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
    assign s_irq[g]   = sub_bus_out[g*BUS_OUT_WIDTH + BO_IRQ];
    assign s_wack[g]  = sub_bus_out[g*BUS_OUT_WIDTH + BO_WACK];
    assign s_rack[g]  = sub_bus_out[g*BUS_OUT_WIDTH + BO_RACK];
    assign s_rdata[g] = sub_bus_out[g*BUS_OUT_WIDTH + BO_RDATA +: 32];
    assign sub_bus_in[g*BUS_IN_WIDTH +: BUS_IN_WIDTH] =
      {sub_be[g], sub_wdata[g], sub_addr[g], sub_wr[g], sub_rd[g], bus_reset_l, bus_clk};
  end

  assign bus_out = {rd_data_q, rd_ack_q, wr_ack_q, irq_q};
  assign busy    = (state == BUSY);

  function automatic logic [31:0] win_mask(input int i);
    logic [63:0] m;
    m = (64'd1 << ADDRWIDTHS[8*i +: 8]) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic [31:0] win_base(input int i);
    return BASE_ADDRS[32*i +: 32];
  endfunction

  logic             hit;
  logic [SEL_W-1:0] hit_idx;
  logic [31:0]      fwd_addr;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    fwd_addr = '0;
    // Scan downwards so the lowest matching index is the one left standing.
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if ((p_addr & ~win_mask(i)) == (win_base(i) & ~win_mask(i))) begin
        hit      = 1'b1;
        hit_idx  = SEL_W'(i);
        fwd_addr = (win_base(i) & ~win_mask(i)) | (p_addr & win_mask(i));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      state         <= IDLE;
      sel           <= '0;
      kind_rd       <= 1'b0;
      cnt           <= '0;
      sub_rd        <= '0;
      sub_wr        <= '0;
      irq_q         <= 1'b0;
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
      rd_data_q     <= '0;
      timeout_pulse <= 1'b0;
      drop_pulse    <= 1'b0;
      timeout_count <= '0;
      // NOTE: these per-window arrays drive output ports, so they are reset like any other register.
      for (int i = 0; i < NUM_WIN; i++) begin
        sub_addr[i]  <= '0;
        sub_wdata[i] <= '0;
        sub_be[i]    <= '0;
      end
    end else begin
      sub_rd        <= '0;
      sub_wr        <= '0;
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
      rd_data_q     <= '0;
      timeout_pulse <= 1'b0;
      drop_pulse    <= 1'b0;
      irq_q         <= |s_irq;

      case (state)
        IDLE: begin
          if (hit && (p_rd || p_wr)) begin
            sub_rd[hit_idx]    <= p_rd;
            sub_wr[hit_idx]    <= p_wr & ~p_rd;
            sub_addr[hit_idx]  <= fwd_addr;
            sub_wdata[hit_idx] <= p_wdata;
            sub_be[hit_idx]    <= p_be;
            sel                <= hit_idx;
            kind_rd            <= p_rd;
            cnt                <= '0;
            state              <= BUSY;
            drop_pulse         <= p_rd & p_wr;
          end
        end
        BUSY: begin
          if (hit && (p_rd || p_wr)) drop_pulse <= 1'b1;
          // A real ack on the timeout cycle takes priority over forced completion.
          if (kind_rd && s_rack[sel]) begin
            rd_ack_q  <= 1'b1;
            rd_data_q <= s_rdata[sel];
            state     <= IDLE;
          end else if (!kind_rd && s_wack[sel]) begin
            wr_ack_q <= 1'b1;
            state    <= IDLE;
          end else if (cnt == 16'(TIMEOUT)) begin
            rd_ack_q      <= kind_rd;
            wr_ack_q      <= ~kind_rd;
            rd_data_q     <= kind_rd ? TIMEOUT_DATA : 32'h0;
            timeout_pulse <= 1'b1;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_window_multi.sv
// Directed self-checking bench for bus_window_multi (4 windows, TIMEOUT=16).
module tb_bus_window_multi;

  localparam int BIW = 72;
  localparam int BOW = 35;
  localparam int NW  = 4;

  logic              bus_clk = 1'b0;
  logic              bus_reset_l;
  logic [BIW-1:0]    bus_in;
  logic [BOW-1:0]    bus_out;
  logic [NW*BIW-1:0] sub_bus_in;
  logic [NW*BOW-1:0] sub_bus_out;
  logic              busy, timeout_pulse, drop_pulse;
  logic [7:0]        timeout_count;

  int errors = 0;
  int checks = 0;

  bus_window_multi #(.TIMEOUT(16)) dut (
    .bus_clk      (bus_clk),
    .bus_reset_l  (bus_reset_l),
    .bus_in       (bus_in),
    .bus_out      (bus_out),
    .sub_bus_in   (sub_bus_in),
    .sub_bus_out  (sub_bus_out),
    .busy         (busy),
    .timeout_pulse(timeout_pulse),
    .drop_pulse   (drop_pulse),
    .timeout_count(timeout_count)
  );

  always #5 bus_clk = ~bus_clk;

  function automatic logic s_rd(input int i);           return sub_bus_in[i*BIW + 2];       endfunction
  function automatic logic s_wr(input int i);           return sub_bus_in[i*BIW + 3];       endfunction
  function automatic logic s_rstl(input int i);         return sub_bus_in[i*BIW + 1];       endfunction
  function automatic logic [31:0] s_addr(input int i);  return sub_bus_in[i*BIW + 4 +: 32];  endfunction
  function automatic logic [31:0] s_wdata(input int i); return sub_bus_in[i*BIW + 36 +: 32]; endfunction
  function automatic logic [3:0] s_be(input int i);     return sub_bus_in[i*BIW + 68 +: 4];  endfunction
  function automatic logic p_irq();                     return bus_out[0];                  endfunction
  function automatic logic p_wack();                    return bus_out[1];                  endfunction
  function automatic logic p_rack();                    return bus_out[2];                  endfunction
  function automatic logic [31:0] p_rdata();            return bus_out[34:3];               endfunction

  task automatic step();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be);
    bus_in = '0;
    bus_in[2] = rd;
    bus_in[3] = wr;
    bus_in[4 +: 32] = addr;
    bus_in[36 +: 32] = wdata;
    bus_in[68 +: 4] = be;
  endtask

  task automatic sub_ack(input int w, input logic rd, input logic wr, input logic [31:0] d);
    sub_bus_out = '0;
    sub_bus_out[w*BOW + 1] = wr;
    sub_bus_out[w*BOW + 2] = rd;
    sub_bus_out[w*BOW + 3 +: 32] = d;
  endtask

  task automatic test_reset();
    bus_reset_l = 1'b0;
    bus_in = '0;
    sub_bus_out = '0;
    #12;
    checks++; if (bus_out !== '0) begin errors++; $display("FAIL reset_bus_out: got %h want 0", bus_out); end
    checks++; if ({busy, timeout_pulse, drop_pulse} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, timeout_pulse, drop_pulse}); end
    checks++; if (timeout_count !== 8'd0) begin errors++; $display("FAIL reset_tcount: got %0d want 0", timeout_count); end
    for (int w = 0; w < NW; w++) begin
      checks++;
      if ({s_rd(w), s_wr(w), s_addr(w), s_wdata(w), s_be(w), s_rstl(w)} !== '0) begin
        errors++; $display("FAIL reset_sub%0d: rd=%b wr=%b addr=%h rst_l=%b want all 0", w, s_rd(w), s_wr(w), s_addr(w), s_rstl(w));
      end
    end
    @(negedge bus_clk);
    bus_reset_l = 1'b1;
    step();
    checks++; if (s_rstl(2) !== 1'b1) begin errors++; $display("FAIL sub_reset_l_release: got %b want 1", s_rstl(2)); end
  endtask

  task automatic test_write();
    req(1'b0, 1'b1, 32'h204, 32'h1234_5678, 4'hF);
    step();
    bus_in = '0;
    checks++; if ({s_wr(2), s_rd(2)} !== 2'b10) begin errors++; $display("FAIL wr_sub2_req: got wr/rd=%b want 10", {s_wr(2), s_rd(2)}); end
    checks++; if (s_addr(2) !== 32'h204) begin errors++; $display("FAIL wr_sub2_addr: got %h want 204", s_addr(2)); end
    checks++; if (s_wdata(2) !== 32'h1234_5678 || s_be(2) !== 4'hF) begin errors++; $display("FAIL wr_sub2_data: got %h/%h want 12345678/f", s_wdata(2), s_be(2)); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
    for (int w = 0; w < NW; w++) begin
      if (w == 2) continue;
      checks++;
      if ({s_rd(w), s_wr(w), s_addr(w)} !== '0) begin
        errors++; $display("FAIL wr_quiet_sub%0d: rd=%b wr=%b addr=%h want 0", w, s_rd(w), s_wr(w), s_addr(w));
      end
    end
    step();
    checks++; if (s_wr(2) !== 1'b0 || s_addr(2) !== 32'h204) begin errors++; $display("FAIL wr_req_single: got wr=%b addr=%h want 0/204", s_wr(2), s_addr(2)); end
    step();
    checks++; if (p_wack() !== 1'b0) begin errors++; $display("FAIL wr_early_ack: got %b want 0", p_wack()); end
    sub_ack(2, 1'b0, 1'b1, 32'h0);
    step();
    sub_bus_out = '0;
    checks++; if ({p_wack(), p_rack(), busy} !== 3'b100) begin errors++; $display("FAIL wr_ack: got wack/rack/busy=%b want 100", {p_wack(), p_rack(), busy}); end
    step();
    checks++; if (p_wack() !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse: got %b want 0", p_wack()); end
  endtask

  task automatic test_read();
    req(1'b1, 1'b0, 32'h1F0, 32'h0, 4'h0);
    step();
    bus_in = '0;
    checks++; if (s_rd(1) !== 1'b1 || s_addr(1) !== 32'h1F0) begin errors++; $display("FAIL rd_sub1_req: got rd=%b addr=%h want 1/1f0", s_rd(1), s_addr(1)); end
    sub_bus_out = '0;
    sub_bus_out[1*BOW + 1] = 1'b1;
    sub_bus_out[0*BOW + 2] = 1'b1;
    sub_bus_out[0*BOW + 3 +: 32] = 32'h1111_1111;
    step();
    sub_bus_out = '0;
    checks++; if ({p_rack(), p_wack(), busy} !== 3'b001 || p_rdata() !== 32'h0) begin errors++; $display("FAIL rd_stray_ack: got rack/wack/busy=%b data=%h want 001/0", {p_rack(), p_wack(), busy}, p_rdata()); end
    sub_ack(1, 1'b1, 1'b0, 32'hCAFE_F00D);
    step();
    sub_bus_out = '0;
    checks++; if (p_rack() !== 1'b1 || p_rdata() !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_ack: got %b/%h want 1/cafef00d", p_rack(), p_rdata()); end
    step();
    checks++; if (p_rack() !== 1'b0 || p_rdata() !== 32'h0) begin errors++; $display("FAIL rd_ack_pulse: got %b/%h want 0/0", p_rack(), p_rdata()); end
  endtask

  task automatic test_timeout();
    int early;
    req(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    step();
    bus_in = '0;
    checks++; if (s_rd(3) !== 1'b1) begin errors++; $display("FAIL to_sub3_req: got %b want 1", s_rd(3)); end
    early = 0;
    for (int c = 2; c <= 17; c++) begin
      step();
      if (p_rack() || p_wack() || timeout_pulse) early++;
    end
    checks++; if (early !== 0 || busy !== 1'b1) begin errors++; $display("FAIL to_early: got %0d early acks busy=%b want 0/1", early, busy); end
    step();
    checks++; if (p_rack() !== 1'b1 || p_rdata() !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_ack: got %b/%h want 1/deadbeef", p_rack(), p_rdata()); end
    checks++; if ({timeout_pulse, busy} !== 2'b10 || timeout_count !== 8'd1) begin errors++; $display("FAIL to_pulse: got pulse/busy=%b count=%0d want 10/1", {timeout_pulse, busy}, timeout_count); end
    sub_ack(3, 1'b1, 1'b0, 32'h1234_5678);
    step();
    sub_bus_out = '0;
    checks++; if ({p_rack(), timeout_pulse, busy} !== 3'b000 || timeout_count !== 8'd1) begin errors++; $display("FAIL to_late_ack: got rack/pulse/busy=%b count=%0d want 000/1", {p_rack(), timeout_pulse, busy}, timeout_count); end
    req(1'b1, 1'b0, 32'h010, 32'h0, 4'h0);
    step();
    bus_in = '0;
    for (int c = 2; c <= 17; c++) step();
    sub_ack(0, 1'b1, 1'b0, 32'hA5A5_0017);
    step();
    sub_bus_out = '0;
    checks++; if (p_rack() !== 1'b1 || p_rdata() !== 32'hA5A5_0017) begin errors++; $display("FAIL to_edge_ack: got %b/%h want 1/a5a50017", p_rack(), p_rdata()); end
    checks++; if (timeout_pulse !== 1'b0 || timeout_count !== 8'd1) begin errors++; $display("FAIL to_edge_no_timeout: got pulse=%b count=%0d want 0/1", timeout_pulse, timeout_count); end
  endtask

  task automatic test_drop();
    req(1'b1, 1'b0, 32'h080, 32'h0, 4'h0);
    step();
    bus_in = '0;
    checks++; if (s_rd(0) !== 1'b1) begin errors++; $display("FAIL drop_sub0_req: got %b want 1", s_rd(0)); end
    req(1'b0, 1'b1, 32'h100, 32'h9999_9999, 4'h3);
    step();
    bus_in = '0;
    checks++; if ({drop_pulse, s_wr(1), busy} !== 3'b101) begin errors++; $display("FAIL drop_busy: got drop/sub1wr/busy=%b want 101", {drop_pulse, s_wr(1), busy}); end
    step();
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL drop_pulse_len: got %b want 0", drop_pulse); end
    sub_ack(0, 1'b1, 1'b0, 32'h5555_AAAA);
    step();
    sub_bus_out = '0;
    checks++; if (p_rack() !== 1'b1 || p_rdata() !== 32'h5555_AAAA) begin errors++; $display("FAIL drop_read_done: got %b/%h want 1/5555aaaa", p_rack(), p_rdata()); end
    step();
    req(1'b1, 1'b1, 32'h200, 32'h0, 4'h0);
    step();
    bus_in = '0;
    checks++; if ({s_rd(2), s_wr(2), drop_pulse} !== 3'b101) begin errors++; $display("FAIL rdwr_both: got rd/wr/drop=%b want 101", {s_rd(2), s_wr(2), drop_pulse}); end
    sub_ack(2, 1'b1, 1'b0, 32'h0BAD_0200);
    step();
    sub_bus_out = '0;
    checks++; if (p_rack() !== 1'b1 || p_rdata() !== 32'h0BAD_0200) begin errors++; $display("FAIL rdwr_ack: got %b/%h want 1/0bad0200", p_rack(), p_rdata()); end
  endtask

  task automatic test_miss();
    int reqs;
    step();
    req(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    step();
    req(1'b0, 1'b1, 32'h400, 32'h0, 4'h0);
    reqs = 0;
    for (int w = 0; w < NW; w++) reqs += int'(s_rd(w)) + int'(s_wr(w));
    step();
    bus_in = '0;
    for (int w = 0; w < NW; w++) reqs += int'(s_rd(w)) + int'(s_wr(w));
    checks++; if (reqs !== 0 || busy !== 1'b0) begin errors++; $display("FAIL miss_forward: got %0d sub reqs busy=%b want 0/0", reqs, busy); end
    step();
    checks++; if ({p_rack(), p_wack(), drop_pulse, timeout_pulse} !== 4'b0000) begin errors++; $display("FAIL miss_quiet: got %b want 0000", {p_rack(), p_wack(), drop_pulse, timeout_pulse}); end
  endtask

  task automatic test_irq();
    sub_bus_out = '0;
    sub_bus_out[3*BOW] = 1'b1;
    #1;
    checks++; if (p_irq() !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b want 0", p_irq()); end
    step();
    checks++; if (p_irq() !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", p_irq()); end
    sub_bus_out = '0;
    step();
    checks++; if (p_irq() !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", p_irq()); end
  endtask

  task automatic test_back_to_back();
    req(1'b0, 1'b1, 32'h300, 32'h0000_0300, 4'h1);
    step();
    bus_in = '0;
    sub_ack(3, 1'b0, 1'b1, 32'h0);
    step();
    sub_bus_out = '0;
    checks++; if (p_wack() !== 1'b1) begin errors++; $display("FAIL b2b_first_ack: got %b want 1", p_wack()); end
    step();
    req(1'b1, 1'b0, 32'h204, 32'h0, 4'h0);
    step();
    bus_in = '0;
    checks++; if (s_rd(2) !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got rd=%b busy=%b want 1/1", s_rd(2), busy); end
    sub_ack(2, 1'b1, 1'b0, 32'h0000_2040);
    step();
    sub_bus_out = '0;
    checks++; if (p_rack() !== 1'b1 || p_rdata() !== 32'h0000_2040) begin errors++; $display("FAIL b2b_second_ack: got %b/%h want 1/00002040", p_rack(), p_rdata()); end
  endtask

  task automatic test_reset_mid();
    step();
    req(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    step();
    bus_in = '0;
    step();
    bus_reset_l = 1'b0;
    #1;
    checks++; if (bus_out !== '0 || busy !== 1'b0 || timeout_count !== 8'd0) begin errors++; $display("FAIL rstmid_out: got bus_out=%h busy=%b count=%0d want 0/0/0", bus_out, busy, timeout_count); end
    checks++; if (s_rd(1) !== 1'b0 || s_addr(1) !== 32'h0) begin errors++; $display("FAIL rstmid_sub1: got rd=%b addr=%h want 0/0", s_rd(1), s_addr(1)); end
    @(negedge bus_clk);
    bus_reset_l = 1'b1;
    step();
    sub_ack(1, 1'b1, 1'b0, 32'h0000_0077);
    step();
    sub_bus_out = '0;
    checks++; if ({p_rack(), busy} !== 2'b00 || p_rdata() !== 32'h0) begin errors++; $display("FAIL rstmid_stale_ack: got rack/busy=%b data=%h want 00/0", {p_rack(), busy}, p_rdata()); end
    req(1'b0, 1'b1, 32'h000, 32'hFEED_0000, 4'hC);
    step();
    bus_in = '0;
    checks++; if (s_wr(0) !== 1'b1 || s_be(0) !== 4'hC) begin errors++; $display("FAIL rstmid_next_req: got wr=%b be=%h want 1/c", s_wr(0), s_be(0)); end
    sub_ack(0, 1'b0, 1'b1, 32'h0);
    step();
    sub_bus_out = '0;
    checks++; if (p_wack() !== 1'b1) begin errors++; $display("FAIL rstmid_next_ack: got %b want 1", p_wack()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_drop();
    test_miss();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
